shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
Frame controller for a parameterised serial shift register. It loads a parallel word, sequences L shifts at a programmable bit rate, and captures serial input into a parallel receive word (full-duplex). Each frame is 1..N bits, LSB-first or MSB-first. It sits between a parallel requester (start/busy/done handshake) and a serial line (so/si with a bit strobe).

Parameters:
N, 8, shift register width in bits (N >= 2).
DIV, 1, clock cycles per bit period (DIV >= 1).
LW (localparam), $clog2(N+1), width of the len port.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  frame request; sampled on the rising edge, honoured only in IDLE.
load_data  input  N  transmit word; captured on the accepting edge.
len  input  LW  frame length in bits; captured on the accepting edge. 0 or >N means N.
lsb_first  input  1  direction; captured on the accepting edge. 1 = LSB first.
si  input  1  serial input; sampled on each bit-tick edge.
so  output  1  serial output; current transmit bit in SHIFT, 0 otherwise.
shift_en  output  1  bit strobe; high for one cycle at the end of each bit period (tick).
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse; rx_data is valid from this cycle on.
rx_data  output  N  received word, right-aligned, zero-extended; holds until the next done.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - Shift register, bit counter, divider counter and rx_data = 0.
  - so, shift_en, busy, done = 0.
  - Reset takes effect immediately, including mid-frame. The frame is abandoned and rx_data is not updated.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - On a rising edge with start=1, latch L = len (clamped as above) and the direction.
  - Load the register: lsb_first=1 loads load_data. lsb_first=0 loads load_data << (N-L), so load_data[L-1] is sent first.
  - Set the bit counter to L and the divider to 0, then go to SHIFT.
- SHIFT:
  - Divider counts 0..DIV-1. Tick = (divider == DIV-1); the divider wraps to 0 on a tick.
  - shift_en = tick, combinational from state and divider.
  - so = reg[0] if LSB-first, reg[N-1] if MSB-first.
  - On a tick edge, LSB-first: reg <= {si, reg[N-1:1]}.
  - On a tick edge, MSB-first: reg <= {reg[N-2:0], si}.
  - The bit counter decrements on each tick.
  - On the tick where the counter == 1, go to DONE and load rx_data in the same edge:
    - LSB-first: rx_data = shifted reg >> (N-L). The first received bit lands at rx_data[0].
    - MSB-first: rx_data = shifted reg. The first received bit lands at rx_data[L-1] and the upper bits are 0.
- DONE: done=1 for exactly one cycle, busy=0, so=0, then go to IDLE. start is ignored in DONE.
- start while in SHIFT or DONE is ignored. It is not queued.
- Latency:
  - Accepting edge at k. busy is high from k to k + L*DIV.
  - done is high in the cycle after edge k + L*DIV.
  - The earliest next accepting edge is k + L*DIV + 2.
  - Tick edges fall at k + i*DIV for i = 1..L.
- so changes only after tick edges (or on entry to SHIFT). It is stable for the DIV cycles of each bit.
- load_data, len, lsb_first and si are don't-care outside their sample edges.

Test Plan:
- N=8, DIV=1, so looped back to si, start with load_data=0xA5, len=8, lsb_first=1.
  -> so = 1,0,1,0,0,1,0,1 on successive cycles. shift_en high for 8 cycles. done pulses 8 edges after acceptance. rx_data = 0xA5.
- N=8, DIV=1, si=1, load_data=0x0B, len=4, lsb_first=0.
  -> so = 1,0,1,1. busy high for 4 cycles. rx_data = 0x0F.
- N=8, DIV=4, len=0 (treated as 8), load_data=0x3C, lsb_first=1.
  -> shift_en pulses at edges +4,+8,...,+32. done in the cycle after edge +32. Each so bit is held for 4 cycles.
- Handshake: start held high through a frame.
  -> No re-acceptance in SHIFT or DONE. A second frame is accepted at edge k + L*DIV + 2. Exactly one done pulse per frame.
- Reset mid-frame: drop rst_n at the 3rd bit of a len=8 frame with rx_data=0x5A from the prior frame.
  -> so, busy, shift_en, done go to 0 immediately. rx_data = 0. A following frame completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - serial shift frame controller: parallel load, L-bit full-duplex shift, parallel capture
module shift_sequencer #(
    parameter  int N   = 8,
    parameter  int DIV = 1,
    localparam int LW  = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  load_data,
    input  logic [LW-1:0] len,
    input  logic          lsb_first,
    input  logic          si,
    output logic          so,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  rx_data
);

    localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
    localparam logic [LW-1:0]  N_LW     = LW'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [N-1:0]   sreg;
    logic [LW-1:0]  cnt;
    logic [LW-1:0]  len_q;
    logic [DW-1:0]  div_cnt;
    logic           lsb_q;

    logic [LW-1:0]  len_eff;
    logic [N-1:0]   load_word;
    logic [N-1:0]   shifted;
    logic           tick;

    // Zero or oversize lengths mean a full-width frame.
    always_comb begin
        len_eff   = (len == '0 || len > N_LW) ? N_LW : len;
        load_word = lsb_first ? load_data : (load_data << (N_LW - len_eff));
        tick      = (state == S_SHIFT) && (div_cnt == DIV_LAST);
        shifted   = lsb_q ? {si, sreg[N-1:1]} : {sreg[N-2:0], si};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        so         = 1'b0;
        shift_en   = tick;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                so   = lsb_q ? sreg[0] : sreg[N-1];
                if (tick && cnt == LW'(1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            cnt     <= '0;
            len_q   <= '0;
            div_cnt <= '0;
            lsb_q   <= 1'b0;
            rx_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sreg    <= load_word;
                        cnt     <= len_eff;
                        len_q   <= len_eff;
                        lsb_q   <= lsb_first;
                        div_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (tick) begin
                        div_cnt <= '0;
                        sreg    <= shifted;
                        cnt     <= cnt - 1'b1;
                        // LSB-first frames land in the top L bits; slide them down to bit 0.
                        if (cnt == LW'(1)) begin
                            rx_data <= lsb_q ? (shifted >> (N_LW - len_q)) : shifted;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
